// File: rtl/memory_stage_sb.sv
// MEM-stage data path: posted-store buffer in front of a byte-maskable data RAM.
// Define SB_FORWARD_EN for byte-wise store-to-load forwarding; otherwise matching loads stall.
module memory_stage_sb #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 1024,
   parameter int SB_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        MEM_MemRead_i,
   input  logic                        MEM_MemWrite_i,
   input  logic [2:0]                  MEM_funct3_i,
   input  logic [DATA_WIDTH-1:0]       MEM_addr_i,
   input  logic [DATA_WIDTH-1:0]       MEM_wr_data_i,
   output logic                        MEM_stall_o,
   output logic [DATA_WIDTH-1:0]       MEM_rd_data_o,
   output logic                        MEM_rd_valid_o,
   output logic                        MEM_misalign_o,
   output logic [$clog2(SB_DEPTH):0]   sb_count_o
);

   localparam int AW = $clog2(MEM_DEPTH);
   localparam int PW = $clog2(SB_DEPTH);
   localparam int CW = PW + 1;
   localparam int NB = DATA_WIDTH / 8;

   typedef struct packed {
      logic [AW-1:0]         idx;
      logic [NB-1:0]         mask;
      logic [DATA_WIDTH-1:0] data;
   } sb_entry_t;

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
   sb_entry_t             sb_q  [SB_DEPTH];
   sb_entry_t             sb_new;

   logic [PW-1:0]         head_q, head_d, tail_q, tail_d, slot;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d, merged, shifted;
   logic                  rd_valid_q, rd_valid_d, misalign_q, misalign_d;
   logic                  is_byte, is_half, misaligned, req_rd, req_wr;
   logic                  full_stall, load_stall, load_ok, push, drain;
   logic [AW-1:0]         word_idx;
   logic [1:0]            boff;
   logic                  unused_addr;

   assign word_idx    = MEM_addr_i[AW+1:2];
   assign boff        = MEM_addr_i[1:0];
   assign unused_addr = ^MEM_addr_i[DATA_WIDTH-1:AW+2];
   assign is_byte     = (MEM_funct3_i[1:0] == 2'b00);
   assign is_half     = (MEM_funct3_i[1:0] == 2'b01);
   assign misaligned  = (MEM_MemRead_i | MEM_MemWrite_i) &
                        ((is_half & boff[0]) | (!is_byte & !is_half & (boff != 2'b00)));
   // A simultaneous read and write serves the read; the write is dropped.
   assign req_rd      = MEM_MemRead_i & !misaligned;
   assign req_wr      = MEM_MemWrite_i & !MEM_MemRead_i & !misaligned;

   // Walk valid entries oldest to youngest so younger stores win per byte.
   always_comb begin
      merged     = mem_q[word_idx];
      load_stall = 1'b0;
      slot       = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         slot = head_q + PW'(i);
         if ((CW'(i) < count_q) && (sb_q[slot].idx == word_idx)) begin
`ifdef SB_FORWARD_EN
            for (int b = 0; b < NB; b++) begin
               if (sb_q[slot].mask[b]) merged[8*b +: 8] = sb_q[slot].data[8*b +: 8];
            end
`else
            load_stall = req_rd;
`endif
         end
      end
   end

   always_comb begin
      full_stall  = req_wr & (count_q == CW'(SB_DEPTH));
      push        = req_wr & !full_stall & !rst;
      drain       = !rst & (count_q != '0) &
                    ((!MEM_MemRead_i & (!MEM_MemWrite_i | full_stall)) | load_stall);
      load_ok     = req_rd & !load_stall;
      MEM_stall_o = full_stall | load_stall;

      head_d  = head_q + PW'(drain);
      tail_d  = tail_q + PW'(push);
      count_d = count_q + CW'(push) - CW'(drain);

      sb_new.idx  = word_idx;
      sb_new.mask = is_byte ? (NB'(1) << boff) : is_half ? (NB'(3) << boff) : '1;
      sb_new.data = MEM_wr_data_i << {boff, 3'b000};

      shifted    = merged >> {boff, 3'b000};
      rd_valid_d = load_ok;
      misalign_d = misaligned;
      rd_data_d  = rd_data_q;
      if (misaligned) begin
         rd_data_d = '0;
      end else if (load_ok) begin
         if (is_byte)
            rd_data_d = MEM_funct3_i[2] ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                                        : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
         else if (is_half)
            rd_data_d = MEM_funct3_i[2] ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                                        : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
         else
            rd_data_d = shifted;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         misalign_q <= misalign_d;
      end
   end

   // NOTE: RAM and entry payloads are never reset; pointers and count alone define validity.
   always_ff @(posedge clk) begin
      if (drain) begin
         for (int b = 0; b < NB; b++) begin
            if (sb_q[head_q].mask[b])
               mem_q[sb_q[head_q].idx][8*b +: 8] <= sb_q[head_q].data[8*b +: 8];
         end
      end
      if (push) sb_q[tail_q] <= sb_new;
   end

   assign MEM_rd_data_o  = rd_data_q;
   assign MEM_rd_valid_o = rd_valid_q;
   assign MEM_misalign_o = misalign_q;
   assign sb_count_o     = count_q;

endmodule

// File: tb/tb_memory_stage_sb.sv
// Self-checking bench for memory_stage_sb: directed spec scenarios plus randomized traffic
// checked against a byte-level store-queue model (honours SB_FORWARD_EN).
module tb_memory_stage_sb;

   localparam int SB_DEPTH = 4;
`ifdef SB_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        rd, wr;
   logic [2:0]  f3;
   logic [31:0] addr, wdata;
   logic        stall, rvalid, mis;
   logic [31:0] rdata;
   logic [2:0]  cnt;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] addr;
      int unsigned n;
      logic [31:0] data;
   } st_t;

   st_t        sbq[$];
   logic [7:0] ram_m [4096];

   always #5 clk = ~clk;

   memory_stage_sb #(.DATA_WIDTH(32), .MEM_DEPTH(1024), .SB_DEPTH(SB_DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .MEM_MemRead_i (rd),
      .MEM_MemWrite_i(wr),
      .MEM_funct3_i  (f3),
      .MEM_addr_i    (addr),
      .MEM_wr_data_i (wdata),
      .MEM_stall_o   (stall),
      .MEM_rd_data_o (rdata),
      .MEM_rd_valid_o(rvalid),
      .MEM_misalign_o(mis),
      .sb_count_o    (cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned nbytes(input logic [2:0] f);
      if (f[1:0] == 2'b00) return 1;
      if (f[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit hits(input logic [31:0] a);
      foreach (sbq[i]) if (sbq[i].addr[31:2] == a[31:2]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drain_one();
      st_t e;
      e = sbq.pop_front();
      for (int k = 0; k < int'(e.n); k++) ram_m[e.addr + k] = e.data[8*k +: 8];
   endtask

   // Reference load: RAM bytes, overlaid by pending stores in program order, then extended.
   function automatic logic [31:0] mread(input logic [31:0] a, input logic [2:0] f);
      logic [7:0]  w [4];
      logic [31:0] base, val;
      int unsigned n;
      base = {a[31:2], 2'b00};
      for (int k = 0; k < 4; k++) w[k] = ram_m[base + k];
      foreach (sbq[i])
         if (sbq[i].addr[31:2] == a[31:2])
            for (int k = 0; k < int'(sbq[i].n); k++) w[sbq[i].addr[1:0] + k] = sbq[i].data[8*k +: 8];
      n   = nbytes(f);
      val = '0;
      for (int k = 0; k < int'(n); k++) val |= 32'(w[a[1:0] + k]) << (8*k);
      if (!f[2] && n < 4 && val[8*n-1]) val |= ~((32'd1 << (8*n)) - 32'd1);
      return val;
   endfunction

   task automatic step(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, output logic stalled);
      logic        e_stall, e_valid, e_mis;
      logic [31:0] e_data;
      st_t         e;
      @(negedge clk);
      rd = r; wr = w; f3 = f; addr = a; wdata = d;
      e_mis   = (r || w) && (a % nbytes(f) != 0);
      e_stall = 1'b0;
      e_valid = 1'b0;
      e_data  = '0;
      if (e_mis) begin
         e_data = '0;
      end else if (r) begin
         if (!FWD && hits(a)) begin
            e_stall = 1'b1;
            drain_one();
         end else begin
            e_valid = 1'b1;
            e_data  = mread(a, f);
         end
      end else if (w) begin
         if (sbq.size() == SB_DEPTH) begin
            e_stall = 1'b1;
            drain_one();
         end else begin
            e.addr = a; e.n = nbytes(f); e.data = d;
            sbq.push_back(e);
         end
      end else if (sbq.size() > 0) begin
         drain_one();
      end
      #1 check("stall", 32'(stall), 32'(e_stall));
      @(posedge clk);
      #1;
      check("count", 32'(cnt), 32'(sbq.size()));
      check("rd_valid", 32'(rvalid), 32'(e_valid));
      check("misalign", 32'(mis), 32'(e_mis));
      if (e_valid || e_mis) check("rd_data", rdata, e_data);
      stalled = e_stall;
   endtask

   task automatic issue(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d);
      logic st;
      int   tries;
      tries = 0;
      do begin
         step(r, w, f, a, d, st);
         tries++;
      end while (st && tries < 2*SB_DEPTH + 2);
      if (st) begin
         n_total++;
         n_fail++;
         $error("FAIL hold_bound: still stalled after %0d cycles", tries);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
   endtask

   task automatic pulse_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1; rd = 1'b0; wr = 1'b0; f3 = 3'b000; addr = '0; wdata = '0;
      repeat (cycles) @(posedge clk);
      #1;
      sbq.delete();
      check("rst_count", 32'(cnt), 32'd0);
      check("rst_valid", 32'(rvalid), 32'd0);
      check("rst_data", rdata, 32'd0);
      check("rst_misalign", 32'(mis), 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  ld_f3 [6];
      logic [2:0]  rf;
      logic [31:0] ra;
      int          op;
      ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b111};

      pulse_reset(2);

      // Store then load of the same word.
      issue(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      check("lw_fwd_data", rdata, 32'hDEADBEEF);

      // Byte merge with sign/zero extension.
      issue(1'b0, 1'b1, 3'b010, 32'h20, 32'h11223344);
      issue(1'b0, 1'b1, 3'b000, 32'h21, 32'hFFFFFF80);
      issue(1'b1, 1'b0, 3'b000, 32'h21, 32'h0);
      check("lb_0x21", rdata, 32'hFFFFFF80);
      issue(1'b1, 1'b0, 3'b100, 32'h21, 32'h0);
      check("lbu_0x21", rdata, 32'h00000080);
      issue(1'b1, 1'b0, 3'b101, 32'h20, 32'h0);
      check("lhu_0x20", rdata, 32'h00008044);
      idle(4);

      // Back-to-back stores overflow the buffer once.
      for (int i = 0; i < 5; i++) issue(1'b0, 1'b1, 3'b010, 32'h200 + 32'(4*i), 32'hA5000000 + 32'(i));
      check("full_count", 32'(cnt), 32'(SB_DEPTH));
      idle(4);
      check("drained", 32'(cnt), 32'd0);

      // Misaligned requests.
      issue(1'b1, 1'b0, 3'b010, 32'h12, 32'h0);
      issue(1'b0, 1'b1, 3'b001, 32'h13, 32'hBEEF);
      issue(1'b1, 1'b0, 3'b101, 32'h11, 32'h0);

      // Randomized traffic over a small, pre-initialised window.
      for (int i = 0; i < 8; i++) issue(1'b0, 1'b1, 3'b010, 32'h100 + 32'(4*i), $urandom);
      idle(SB_DEPTH);
      for (int t = 0; t < 300; t++) begin
         op = int'($urandom_range(0, 9));
         ra = 32'h100 + 32'($urandom_range(0, 31));
         if (op < 4 || op == 9) rf = ld_f3[$urandom_range(0, 5)];
         else                   rf = 3'(op % 3);
         ra = ra - (ra % nbytes(rf));
         if (op < 4)       issue(1'b1, 1'b0, rf, ra, 32'h0);
         else if (op < 8)  issue(1'b0, 1'b1, rf, ra, $urandom);
         else if (op == 8) idle(1);
         else              issue(1'b1, 1'b1, rf, ra, $urandom);
      end
      idle(SB_DEPTH);

      // Reset discards buffered stores without writing them.
      issue(1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
      idle(SB_DEPTH);
      issue(1'b0, 1'b1, 3'b010, 32'h40, 32'h12345678);
      issue(1'b0, 1'b1, 3'b010, 32'h44, 32'h9ABCDEF0);
      issue(1'b0, 1'b1, 3'b010, 32'h48, 32'h0F0F0F0F);
      check("pre_rst_count", 32'(cnt), 32'd3);
      pulse_reset(1);
      issue(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
      check("rst_discard", rdata, 32'hCAFEF00D);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
